// File: rtl/node_traffic_source.sv
// Per-node traffic injector: creates data packets and forward ants, buffers them
// in a circular queue and presents the head to the router via valid/enable.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef CREATE_ANT_PERIOD
`define CREATE_ANT_PERIOD 16
`endif
`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 4
`endif

package node_traffic_pkg;
    localparam int X_NODES      = `X_NODES;
    localparam int Y_NODES      = `Y_NODES;
    localparam int NUM_MEMORIES = 4;

    typedef struct packed {
        logic [7:0]                    id;
        logic [7:0]                    x_source;
        logic [7:0]                    y_source;
        logic [7:0]                    x_dest;
        logic [7:0]                    y_dest;
        logic                          ant;
        logic                          backward;
        logic                          measure;
        logic [63:0]                   timestamp;
        logic [NUM_MEMORIES-1:0][15:0] memory;
        logic [3:0]                    num_memories;
    } packet_t;
endpackage

module node_traffic_source
    import node_traffic_pkg::*;
#(
    parameter int          X_POS       = 0,
    parameter int          Y_POS       = 0,
    parameter int          PACKET_RATE = 100,
    parameter int          ANT_PERIOD  = `CREATE_ANT_PERIOD,
    parameter int          QUEUE_DEPTH = `INPUT_QUEUE_DEPTH*8,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_gen_en,
    input  logic                           i_measure,
    input  logic [63:0]                    i_time,
    input  logic                           i_en,
    output packet_t                        o_data,
    output logic                           o_data_val,
    output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count,
    output logic [31:0]                    o_gen_count,
    output logic [31:0]                    o_drop_count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(ANT_PERIOD);
    localparam logic [CW-1:0] DEPTH_C    = CW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(ANT_PERIOD - 1);
    localparam logic [31:0]   LFSR_MASK  = 32'h8020_0003;

    logic [31:0]   lfsr;
    logic [PW-1:0] phase;
    logic [7:0]    id_cnt;
    packet_t       mem [QUEUE_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0] count, count_next;
    logic [15:0]   r_rate;
    logic [7:0]    x_dest, y_dest;
    logic          ant_now, create, pop, push;
    packet_t       new_pkt;

    always_comb begin
        r_rate  = lfsr[15:0] % 16'd100;
        x_dest  = lfsr[23:16] % 8'(X_NODES);
        y_dest  = lfsr[31:24] % 8'(Y_NODES);
        ant_now = (phase == PHASE_LAST);
        create  = i_gen_en && (ant_now || (r_rate < 16'(PACKET_RATE)));
        pop     = o_data_val && i_en;
        push    = create && ((count != DEPTH_C) || pop);
        rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        new_pkt           = '0;
        new_pkt.id        = id_cnt;
        new_pkt.x_source  = 8'(X_POS);
        new_pkt.y_source  = 8'(Y_POS);
        new_pkt.x_dest    = x_dest;
        new_pkt.y_dest    = y_dest;
        new_pkt.ant       = ant_now;
        new_pkt.measure   = i_measure;
        new_pkt.timestamp = i_time;
    end

    // Storage kept free of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (reset_n && push)
            mem[wr_ptr] <= new_pkt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr         <= SEED;
            phase        <= '0;
            id_cnt       <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            o_data       <= '0;
            o_data_val   <= 1'b0;
            o_gen_count  <= '0;
            o_drop_count <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
            if (i_gen_en)
                phase <= ant_now ? '0 : phase + PW'(1);
            if (create) begin
                id_cnt <= id_cnt + 8'd1;
                if (o_gen_count != 32'hFFFF_FFFF)
                    o_gen_count <= o_gen_count + 32'd1;
                if (!push && o_drop_count != 32'hFFFF_FFFF)
                    o_drop_count <= o_drop_count + 32'd1;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_next;
            count      <= count_next;
            o_data_val <= (count_next != '0);
            // New head is the packet being written when it lands on the read slot.
            if (count_next != '0)
                o_data <= (push && (wr_ptr == rd_next)) ? new_pkt : mem[rd_next];
        end
    end

    assign o_queue_count = count;
endmodule

// File: doc/node_traffic_source.md
Name: node_traffic_source

Overview:
- Per-node traffic injector sitting directly upstream of `network` input port i.
- Each cycle, decides whether to create a data packet (offered rate) or a forward ant (fixed period) and buffers it in a node queue of NODE_QUEUE_DEPTH entries.
- Presents the queue head to the router with a valid/enable handshake.
- Replaces ad-hoc bench generation so that injection is identical in simulation and in FPGA traffic experiments.

Parameters:
- X_POS, 0, x coordinate of this node; drives x_source.
- Y_POS, 0, y coordinate of this node; drives y_source.
- PACKET_RATE, 100, offered data traffic, percent of cycles (0..100).
- ANT_PERIOD, `CREATE_ANT_PERIOD, cycles between forward-ant creations; must be >= 2.
- QUEUE_DEPTH, `INPUT_QUEUE_DEPTH*8, node queue entries; power of two, >= 2.
- SEED, 32'h1, LFSR seed; must be nonzero. Each instance gets a distinct value.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- i_gen_en  in  1  generation enable. 0 stops creation, but the queue keeps draining.
- i_measure  in  1  copied into the measure field of generated packets.
- i_time  in  64  global cycle time; copied into timestamp.
- i_en  in  1  router can accept this cycle (network o_en[i]).
- o_data  out  packet_t  queue head packet.
- o_data_val  out  1  queue head valid.
- o_queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.
- o_gen_count  out  32  packets created (data + ant), including dropped ones.
- o_drop_count  out  32  packets discarded because the queue was full.

Behaviour:
- Reset:
  - Queue empty; o_data_val=0; o_data all zeros.
  - Counters 0; id counter 0; ant phase counter 0; LFSR=SEED.
  - Reset asserted mid-operation discards all queued packets. No partial output.
- Random source:
  - 32-bit Galois LFSR, taps 32,22,2,1. Advances every non-reset cycle regardless of i_gen_en.
  - r_rate = lfsr[15:0] % 100.
  - x_dest = lfsr[23:16] % `X_NODES; y_dest = lfsr[31:24] % `Y_NODES.
  - Self-destination is permitted.
- Creation, evaluated every cycle with i_gen_en=1:
  - Ant phase counter counts 0..ANT_PERIOD-1 and wraps. It counts only while i_gen_en=1.
  - Phase==ANT_PERIOD-1: create ant (ant=1) regardless of PACKET_RATE.
  - Otherwise: create data packet (ant=0) iff r_rate < PACKET_RATE. PACKET_RATE=0 means never; 100 means every cycle.
  - At most one packet per cycle.
- Packet fields:
  - id = 8-bit counter, increments per created packet (dropped ones included); wraps 255->0.
  - x_source=X_POS, y_source=Y_POS.
  - backward=0; all memory fields and num_memories = 0.
  - measure=i_measure; timestamp=i_time sampled in the creation cycle.
- Queue: circular FIFO with read/write pointers and occupancy counter.
  - Push when created and (count<QUEUE_DEPTH or pop this cycle).
  - Full with no pop: packet dropped, o_drop_count++. o_gen_count increments either way.
  - Pop when o_data_val && i_en.
  - Simultaneous push and pop: count unchanged. When empty, no pop, so a push into an empty queue does not bypass to the output.
  - A packet created at edge N is on o_data with o_data_val=1 from edge N+1. Minimum latency 1 cycle.
  - o_data is registered and holds stable while o_data_val && !i_en.
  - o_data is don't-care when o_data_val=0; implement as the last value.
- Counters: 32-bit saturating at 32'hFFFFFFFF.
- i_gen_en deassert: creation stops the next cycle; the queue keeps draining.

Test Plan:
1. Reset, PACKET_RATE=0, ANT_PERIOD=4, i_en=1 for 12 cycles -> exactly 3 ants out, ids 0,1,2, o_drop_count=0, o_queue_count never exceeds 1.
2. PACKET_RATE=100, QUEUE_DEPTH=8, i_en=0 for 20 cycles -> o_queue_count=8, o_gen_count=20, o_drop_count=12. o_data holds id 0 throughout.
3. Continuation of scenario 2, i_gen_en=0, i_en=1 -> 8 packets out with ids 0..7 in order; o_data_val falls after the 8th; count returns to 0.
4. PACKET_RATE=100, queue full, i_en=1 every cycle -> push and pop every cycle, count stays 8, no further drops, no id gaps in the output.
5. Run 300 cycles at PACKET_RATE=100 -> output ids wrap 255->0. Every packet has source=(X_POS,Y_POS) and dest within the mesh. Timestamp equals i_time of the creation cycle.
6. Assert reset_n=0 for 1 cycle with 5 queued -> next cycle o_data_val=0, count=0, counters=0. The same LFSR sequence repeats from SEED.
